// File: rtl/tm1638_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tm1638_scheduler_if
// Brief    : Command-push and key-reply link between the scheduler and spi_fifo.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface tm1638_scheduler_if;
    logic        FIFO_Full;
    logic        FIFO_Data_Valid;
    logic [17:0] FIFO_Data;
    logic        SPI_Data_Valid;
    logic [63:0] SPI_Data;

    modport master (
        input  FIFO_Full,
        output FIFO_Data_Valid,
        output FIFO_Data,
        input  SPI_Data_Valid,
        input  SPI_Data
    );

    modport slave (
        output FIFO_Full,
        input  FIFO_Data_Valid,
        input  FIFO_Data,
        output SPI_Data_Valid,
        output SPI_Data
    );
endinterface
`default_nettype wire

// File: rtl/tm1638_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tm1638_scheduler
// Brief    : Arbitrates TM1638 display refresh and key scan onto the spi_fifo.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tm1638_scheduler #(
    parameter int unsigned SCAN_PERIOD = 250000,
    parameter int unsigned TIMEOUT     = 65535,
    parameter logic [2:0]  BRIGHTNESS  = 3'd7
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [63:0]        i_Segments,
    input  logic [7:0]         i_Leds,
    input  logic               i_Update,
    tm1638_scheduler_if.master bus,
    output logic [7:0]         o_Keys,
    output logic               o_Keys_Valid,
    output logic               o_Key_Timeout,
    output logic               o_Busy
);

    localparam int TMR_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] c_TMR_LAST  = TMR_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [17:0]      c_WORD_MODE = {2'b00, 8'h44, 8'h00};
    localparam logic [17:0]      c_WORD_DISP = {2'b00, 8'h88 | {5'b0, BRIGHTNESS}, 8'h00};
    localparam logic [17:0]      c_WORD_READ = {2'b10, 8'h42, 8'h00};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_MODE   = 3'd1,
        S_WR_DATA   = 3'd2,
        S_DISP_CTRL = 3'd3,
        S_KEY_READ  = 3'd4,
        S_WAIT_KEYS = 3'd5
    } state_t;

    state_t           state_q;
    logic             refresh_pend_q;
    logic             scan_pend_q;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       addr_q;
    logic [63:0]      seg_q;
    logic [7:0]       led_q;
    logic [7:0]       keys_q;
    logic             keys_valid_q;
    logic             timeout_q;

    logic             w_push_state;
    logic             w_push;
    logic [17:0]      w_word;
    logic [7:0]       w_byte;
    logic             w_wrap;
    logic [7:0]       w_keys;
    logic             w_unused;

    // Even addresses carry digit segments, odd addresses carry one LED in bit 0.
    always_comb begin
        w_push_state = 1'b0;
        w_word       = '0;
        w_byte       = addr_q[0] ? {7'b0, led_q[addr_q[3:1]]}
                                 : seg_q[{addr_q[3:1], 3'b000} +: 8];
        case (state_q)
            S_WR_MODE: begin
                w_push_state = 1'b1;
                w_word       = c_WORD_MODE;
            end
            S_WR_DATA: begin
                w_push_state = 1'b1;
                w_word       = {2'b01, 8'hC0 | {4'h0, addr_q}, w_byte};
            end
            S_DISP_CTRL: begin
                w_push_state = 1'b1;
                w_word       = c_WORD_DISP;
            end
            S_KEY_READ: begin
                w_push_state = 1'b1;
                w_word       = c_WORD_READ;
            end
            default: begin
                w_push_state = 1'b0;
                w_word       = '0;
            end
        endcase
    end

    assign w_push   = w_push_state & ~bus.FIFO_Full;
    assign w_wrap   = (tmr_q == c_TMR_LAST);
    assign w_keys   = {bus.SPI_Data[28], bus.SPI_Data[24], bus.SPI_Data[20], bus.SPI_Data[16],
                       bus.SPI_Data[12], bus.SPI_Data[8],  bus.SPI_Data[4],  bus.SPI_Data[0]};
    assign w_unused = ^bus.SPI_Data;

    // Pending flags are set after the FSM case so a same-cycle request survives its clear.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q        <= S_IDLE;
            refresh_pend_q <= 1'b1;
            scan_pend_q    <= 1'b0;
            tmr_q          <= '0;
            cnt_q          <= '0;
            addr_q         <= '0;
            seg_q          <= '0;
            led_q          <= '0;
            keys_q         <= '0;
            keys_valid_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            keys_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            tmr_q        <= w_wrap ? '0 : tmr_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (refresh_pend_q) begin
                        refresh_pend_q <= 1'b0;
                        seg_q          <= i_Segments;
                        led_q          <= i_Leds;
                        state_q        <= S_WR_MODE;
                    end else if (scan_pend_q) begin
                        scan_pend_q    <= 1'b0;
                        state_q        <= S_KEY_READ;
                    end
                end
                S_WR_MODE: begin
                    if (w_push) begin
                        addr_q  <= '0;
                        state_q <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_push) begin
                        addr_q <= addr_q + 4'd1;
                        if (addr_q == 4'd15) begin
                            state_q <= S_DISP_CTRL;
                        end
                    end
                end
                S_DISP_CTRL: begin
                    if (w_push) begin
                        state_q <= S_IDLE;
                    end
                end
                S_KEY_READ: begin
                    if (w_push) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_WAIT_KEYS;
                    end
                end
                S_WAIT_KEYS: begin
                    // cnt_q equals the number of cycles elapsed since the read word was pushed.
                    if (bus.SPI_Data_Valid) begin
                        keys_q       <= w_keys;
                        keys_valid_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (cnt_q >= c_CNT_LAST) begin
                        timeout_q    <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (i_Update) begin
                refresh_pend_q <= 1'b1;
            end
            if (w_wrap) begin
                scan_pend_q <= 1'b1;
            end
        end
    end

    assign bus.FIFO_Data_Valid = w_push;
    assign bus.FIFO_Data       = w_word;
    assign o_Keys              = keys_q;
    assign o_Keys_Valid        = keys_valid_q;
    assign o_Key_Timeout       = timeout_q;
    assign o_Busy              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tm1638_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_tm1638_scheduler
// Brief    : Directed self-checking bench for tm1638_scheduler.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_tm1638_scheduler;

    localparam int          SP     = 100;
    localparam int          TO     = 16;
    localparam logic [17:0] W_MODE = 18'h04400;
    localparam logic [17:0] W_DISP = 18'h08F00;
    localparam logic [17:0] W_READ = 18'h24200;

    localparam logic [63:0] SEG_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [7:0]  LED_A = 8'hA5;
    localparam logic [63:0] SEG_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [7:0]  LED_B = 8'h3C;
    localparam logic [63:0] SEG_C = 64'h1122_3344_5566_7788;
    localparam logic [7:0]  LED_C = 8'h81;
    localparam logic [63:0] SEG_D = 64'h5A5A_0F0F_F0F0_A5A5;
    localparam logic [7:0]  LED_D = 8'h7E;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] seg   = '0;
    logic [7:0]  led   = '0;
    logic        upd   = 1'b0;
    logic [7:0]  keys;
    logic        kv;
    logic        kto;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    tm1638_scheduler_if bus ();

    tm1638_scheduler #(
        .SCAN_PERIOD (SP),
        .TIMEOUT     (TO),
        .BRIGHTNESS  (3'd7)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Segments    (seg),
        .i_Leds        (led),
        .i_Update      (upd),
        .bus           (bus),
        .o_Keys        (keys),
        .o_Keys_Valid  (kv),
        .o_Key_Timeout (kto),
        .o_Busy        (busy)
    );

    always #5 clk = ~clk;

    // Push monitor: every accepted word with the cycle number it was pushed in.
    logic [17:0] pq[$];
    int          pc[$];
    int          cyc      = 0;
    int          bad_push = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.FIFO_Data_Valid === 1'b1) begin
            pq.push_back(bus.FIFO_Data);
            pc.push_back(cyc);
            if (bus.FIFO_Full !== 1'b0) bad_push <= bad_push + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference word for position idx (0..17) of a refresh sequence.
    function automatic logic [17:0] exp_word(input int idx, input logic [63:0] s, input logic [7:0] l);
        int         a;
        logic [7:0] b;
        if (idx == 0)  return W_MODE;
        if (idx == 17) return W_DISP;
        a = idx - 1;
        b = (a % 2 == 0) ? s[8*(a/2) +: 8] : {7'b0, l[(a-1)/2]};
        return {2'b01, 8'hC0 | 8'(a), b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_update;
        tick();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic wait_pushes(input int n, input int budget, output bit ok);
        ok = (pq.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (pq.size() >= n);
        end
    endtask

    task automatic wait_word(input logic [17:0] w, input int budget, output bit ok);
        int st;
        st = pq.size();
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            for (int j = st; j < pq.size(); j++) if (pq[j] == w) ok = 1'b1;
        end
    endtask

    task automatic send_reply(input logic [31:0] bytes);
        bus.SPI_Data       = {32'h0, bytes};
        bus.SPI_Data_Valid = 1'b1;
        tick();
        bus.SPI_Data_Valid = 1'b0;
    endtask

    task automatic test_reset;
        bit ok;
        int rc;
        rst_n = 1'b0;
        bus.FIFO_Full = 1'b0;
        bus.SPI_Data_Valid = 1'b0;
        bus.SPI_Data = '0;
        seg = SEG_A;
        led = LED_A;
        repeat (3) tick();
        n_checks++; if (bus.FIFO_Data_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.FIFO_Data_Valid); end
        n_checks++; if (bus.FIFO_Data !== 18'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.FIFO_Data); end
        n_checks++; if (keys !== 8'h00) begin n_fail++; $display("FAIL reset_keys: got %h want 00", keys); end
        n_checks++; if ({kv, kto, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {kv, kto, busy}); end
        pq.delete();
        pc.delete();
        rst_n = 1'b1;
        rc = cyc;
        wait_pushes(18, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL init_count: got %0d words want 18", pq.size()); end
        if (ok) begin
            for (int i = 0; i < 18; i++) begin
                n_checks++;
                if (pq[i] !== exp_word(i, SEG_A, LED_A)) begin
                    n_fail++; $display("FAIL init_word[%0d]: got %h want %h", i, pq[i], exp_word(i, SEG_A, LED_A));
                end
            end
            n_checks++; if (pc[0] !== rc + 1) begin n_fail++; $display("FAIL init_latency: got cycle %0d want %0d", pc[0], rc + 1); end
            n_checks++; if (pc[17] !== rc + 18) begin n_fail++; $display("FAIL init_contiguous: got cycle %0d want %0d", pc[17], rc + 18); end
        end
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_after: got %b want 0", busy); end
        n_checks++; if (pq.size() !== 18) begin n_fail++; $display("FAIL init_no_extra: got %0d words want 18", pq.size()); end
    endtask

    task automatic test_full_stall;
        bit ok;
        int s;
        int s0;
        seg = SEG_B;
        led = LED_B;
        s = pq.size();
        pulse_update();
        wait_pushes(s + 6, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_pre: got %0d words want %0d", pq.size(), s + 6); end
        bus.FIFO_Full = 1'b1;
        s0 = pq.size();
        seg = SEG_D;
        led = LED_D;
        repeat (5) tick();
        n_checks++; if (pq.size() !== s0) begin n_fail++; $display("FAIL stall_no_push: got %0d words want %0d", pq.size(), s0); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
        n_checks++; if (bus.FIFO_Data !== exp_word(6, SEG_B, LED_B)) begin n_fail++; $display("FAIL stall_hold_word: got %h want %h", bus.FIFO_Data, exp_word(6, SEG_B, LED_B)); end
        bus.FIFO_Full = 1'b0;
        wait_pushes(s + 18, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_count: got %0d words want %0d", pq.size(), s + 18); end
        if (ok) begin
            for (int i = 0; i < 18; i++) begin
                n_checks++;
                if (pq[s+i] !== exp_word(i, SEG_B, LED_B)) begin
                    n_fail++; $display("FAIL stall_word[%0d]: got %h want %h", i, pq[s+i], exp_word(i, SEG_B, LED_B));
                end
            end
            n_checks++; if (pc[s+17] - pc[s] !== 22) begin n_fail++; $display("FAIL stall_span: got %0d cycles want 22", pc[s+17] - pc[s]); end
        end
        n_checks++; if (bad_push !== 0) begin n_fail++; $display("FAIL push_while_full: got %0d pushes want 0", bad_push); end
        repeat (3) tick();
    endtask

    task automatic test_key_scan;
        bit ok;
        wait_word(W_READ, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL scan1_read_word: got none want %h", W_READ); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL scan1_wait_busy: got %b want 1", busy); end
        tick();
        send_reply({8'h11, 8'h00, 8'h01, 8'h10});
        n_checks++; if (keys !== 8'b1100_0110) begin n_fail++; $display("FAIL scan1_keys: got %b want 11000110", keys); end
        n_checks++; if (kv !== 1'b1) begin n_fail++; $display("FAIL scan1_valid: got %b want 1", kv); end
        tick();
        n_checks++; if (kv !== 1'b0) begin n_fail++; $display("FAIL scan1_valid_width: got %b want 0", kv); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL scan1_idle: got %b want 0", busy); end
        send_reply(32'hFFFF_FFFF);
        n_checks++; if ({kv, keys} !== {1'b0, 8'b1100_0110}) begin n_fail++; $display("FAIL stray_reply: got %b/%b want 0/11000110", kv, keys); end
        wait_word(W_READ, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL scan2_read_word: got none want %h", W_READ); end
        tick();
        send_reply({8'h11, 8'h00, 8'h10, 8'h01});
        n_checks++; if ({kv, keys} !== {1'b1, 8'b1100_1001}) begin n_fail++; $display("FAIL scan2_keys: got %b/%b want 1/11001001", kv, keys); end
    endtask

    task automatic test_timeout;
        bit ok;
        bit seen;
        int pcy;
        int tcyc;
        wait_word(W_READ, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL to_read_word: got none want %h", W_READ); end
        pcy  = ok ? pc[pc.size()-1] : cyc;
        seen = 1'b0;
        tcyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (kto === 1'b1) begin
                seen = 1'b1;
                tcyc = cyc;
            end else begin
                tick();
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL to_pulse: got none want pulse"); end
        n_checks++; if (tcyc - pcy !== TO) begin n_fail++; $display("FAIL to_latency: got %0d cycles want %0d", tcyc - pcy, TO); end
        n_checks++; if (keys !== 8'b1100_1001) begin n_fail++; $display("FAIL to_keys_kept: got %b want 11001001", keys); end
        tick();
        n_checks++; if ({kto, busy} !== 2'b00) begin n_fail++; $display("FAIL to_pulse_width: got %b want 00", {kto, busy}); end
        send_reply(32'hFFFF_FFFF);
        n_checks++; if ({kv, keys} !== {1'b0, 8'b1100_1001}) begin n_fail++; $display("FAIL to_late_reply: got %b/%b want 0/11001001", kv, keys); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int pcy;
        int s;
        seg = SEG_C;
        led = LED_C;
        wait_word(W_READ, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_sync: got none want %h", W_READ); end
        pcy = ok ? pc[pc.size()-1] : cyc;
        tick();
        send_reply(32'hFFFF_FFFF);
        s = pq.size();
        while (cyc < pcy + 85) tick();
        upd = 1'b1;
        tick();
        upd = 1'b0;
        while (cyc < pcy + 90) tick();
        seg = SEG_D;
        led = LED_D;
        while (cyc < pcy + 98) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_in_refresh: got %b want 1", busy); end
        upd = 1'b1;
        tick();
        upd = 1'b0;
        wait_pushes(s + 37, 120, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_count: got %0d words want %0d", pq.size() - s, 37); end
        if (ok) begin
            for (int i = 0; i < 18; i++) begin
                n_checks++;
                if (pq[s+i] !== exp_word(i, SEG_C, LED_C)) begin
                    n_fail++; $display("FAIL b2b_first[%0d]: got %h want %h", i, pq[s+i], exp_word(i, SEG_C, LED_C));
                end
                n_checks++;
                if (pq[s+18+i] !== exp_word(i, SEG_D, LED_D)) begin
                    n_fail++; $display("FAIL b2b_second[%0d]: got %h want %h", i, pq[s+18+i], exp_word(i, SEG_D, LED_D));
                end
            end
            n_checks++; if (pq[s+36] !== W_READ) begin n_fail++; $display("FAIL b2b_scan_last: got %h want %h", pq[s+36], W_READ); end
            n_checks++; if (pc[s+18] - pc[s+17] !== 2) begin n_fail++; $display("FAIL b2b_gap1: got %0d want 2", pc[s+18] - pc[s+17]); end
            n_checks++; if (pc[s+36] - pc[s+35] !== 2) begin n_fail++; $display("FAIL b2b_gap2: got %0d want 2", pc[s+36] - pc[s+35]); end
        end
        tick();
        send_reply(32'hFFFF_FFFF);
        repeat (20) tick();
        n_checks++; if (pq.size() !== s + 37) begin n_fail++; $display("FAIL b2b_no_third: got %0d words want %0d", pq.size() - s, 37); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int s;
        int rc;
        seg = SEG_A;
        led = LED_A;
        s = pq.size();
        pulse_update();
        wait_pushes(s + 8, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_pre: got %0d words want %0d", pq.size() - s, 8); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.FIFO_Data_Valid, bus.FIFO_Data} !== 19'h0) begin n_fail++; $display("FAIL mid_push_out: got %h want 0", {bus.FIFO_Data_Valid, bus.FIFO_Data}); end
        n_checks++; if (keys !== 8'h00) begin n_fail++; $display("FAIL mid_keys: got %h want 00", keys); end
        n_checks++; if ({kv, kto, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b want 000", {kv, kto, busy}); end
        repeat (3) tick();
        pq.delete();
        pc.delete();
        rst_n = 1'b1;
        rc = cyc;
        wait_pushes(18, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_restart_count: got %0d words want 18", pq.size()); end
        if (ok) begin
            for (int i = 0; i < 18; i++) begin
                n_checks++;
                if (pq[i] !== exp_word(i, SEG_A, LED_A)) begin
                    n_fail++; $display("FAIL mid_restart_word[%0d]: got %h want %h", i, pq[i], exp_word(i, SEG_A, LED_A));
                end
            end
            n_checks++; if (pc[0] !== rc + 1) begin n_fail++; $display("FAIL mid_restart_latency: got cycle %0d want %0d", pc[0], rc + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_full_stall();
        test_key_scan();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
